cc_reg: RTL
===========

CC_REG -- requirements
Module: cc_reg

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low, sampled on rising clk.
REQ-003 SHALL have port: valid_in  input  1  execute-stage instruction valid.
REQ-004 SHALL have port: icode  input  4  execute-stage instruction code.
REQ-005 SHALL have port: ifun  input  4  execute-stage function code.
REQ-006 SHALL have port: val_a  input  64  ALU operand A (valA).
REQ-007 SHALL have port: val_b  input  64  ALU operand B (valB).
REQ-008 SHALL have port: val_e  input  64  ALU result (valE), produced externally.
REQ-009 SHALL have port: stall  input  1  execute-stage stall; blocks CC update.
REQ-010 SHALL have port: m_exc  input  1  memory-stage instruction has exception status.
REQ-011 SHALL have port: w_exc  input  1  writeback-stage instruction has exception status.
REQ-012 SHALL have port: cf  output  3  condition flags to the condition evaluator; cf[0]=OF, cf[1]=ZF, cf[2]=SF.
REQ-013 SHALL have port: frozen  output  1  high while in state FROZEN.
REQ-014 SHALL have port: upd_cnt  output  16  count of committed CC updates.

Function
REQ-015 SHALL compute next flags combinationally: ZF = (val_e == 0); SF = val_e[63].
REQ-016 SHALL compute OF for ifun 0 (add): OF = (val_a[63]==val_b[63]) and (val_e[63]!=val_a[63]).
REQ-017 SHALL compute OF for ifun 1 (sub, val_e=val_b-val_a): OF = (val_a[63]!=val_b[63]) and (val_e[63]!=val_b[63]).
REQ-018 SHALL compute OF = 0 for ifun 2 (and) and ifun 3 (xor).
REQ-019 SHALL define set_cc = valid_in and icode==4'h6 and ifun<=4'h3 and not stall and not m_exc and not w_exc and state==RUN.
REQ-020 SHALL load the flag register with the computed flags on the rising clk where set_cc=1; latency one cycle to cf.
REQ-021 SHALL hold the flag register unchanged when set_cc=0, including icode 4'h6 with ifun>4'h3.
REQ-022 SHALL implement two states: RUN and FROZEN.
REQ-023 SHALL transition RUN->FROZEN on the rising clk where w_exc=1; FROZEN is left only by reset.
REQ-024 SHALL give w_exc priority over a simultaneous set_cc candidate: no update that cycle.
REQ-025 SHALL drive frozen=1 exactly when state==FROZEN.
REQ-026 SHALL increment upd_cnt by 1 on each committed update; wraps 16'hFFFF -> 16'h0000.

Reset
REQ-027 SHALL on rising clk with rst_n=0 set cf=3'b010 (ZF=1, SF=0, OF=0), state=RUN, frozen=0, upd_cnt=0.
REQ-028 SHALL give reset priority over every other input, including mid-freeze and a simultaneous set_cc.

Configuration
REQ-029 SHALL support macro CC_BYPASS_EN.
REQ-030 SHALL, with CC_BYPASS_EN defined, drive cf combinationally with the computed flags in any cycle where set_cc=1, and with the register otherwise.
REQ-031 SHALL, without CC_BYPASS_EN, drive cf from the register only; zero combinational path from inputs to cf.
REQ-032 SHALL keep register contents, upd_cnt and state identical in both builds.

Verification
REQ-033 SHALL cover: reset released, idle -> cf=3'b010, frozen=0, upd_cnt=0.
REQ-034 SHALL cover: add, val_a=val_b=64'h7FFF_FFFF_FFFF_FFFF, val_e=64'hFFFF_FFFF_FFFF_FFFE -> next cycle cf=3'b101, upd_cnt=1.
REQ-035 SHALL cover: sub, val_a=5, val_b=5, val_e=0 with stall=1 for one cycle, then stall=0 -> cf unchanged during the stall cycle, 3'b010 after, upd_cnt increments once.
REQ-036 SHALL cover: xor with m_exc=1, val_e=64'h8000_0000_0000_0000 -> cf unchanged, upd_cnt unchanged.
REQ-037 SHALL cover: w_exc=1 concurrent with valid add -> frozen=1 next cycle; later OPq instructions ignored; rst_n=0 -> RUN, cf=3'b010.
REQ-038 SHALL cover: build with CC_BYPASS_EN, and val_e=0 with set_cc=1 -> cf=3'b010 in the same cycle; without the macro, the new value appears one cycle later.

Source files
------------

// File: rtl/cc_reg.sv
// Condition-code register: latches OF/ZF/SF from the execute-stage OPq result one cycle after set_cc; stall/exceptions hold it.
// Optional CC_BYPASS_EN forwards the computed flags to cf in the same cycle they are committed.
module cc_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] val_a,
  input  logic [63:0] val_b,
  input  logic [63:0] val_e,
  input  logic        stall,
  input  logic        m_exc,
  input  logic        w_exc,
  output logic [2:0]  cf,
  output logic        frozen,
  output logic [15:0] upd_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cf_reg;
  logic [2:0]  flags_nxt;
  logic        of_nxt;
  logic        zf_nxt;
  logic        sf_nxt;
  logic        set_cc;

  assign zf_nxt = (val_e == 64'd0);
  assign sf_nxt = val_e[63];

  // Signed overflow from operand/result signs; logical ops never overflow.
  always_comb begin
    of_nxt = 1'b0;
    case (ifun)
      4'h0:    of_nxt = (val_a[63] == val_b[63]) && (val_e[63] != val_a[63]);
      4'h1:    of_nxt = (val_a[63] != val_b[63]) && (val_e[63] != val_b[63]);
      default: of_nxt = 1'b0;
    endcase
  end

  assign flags_nxt = {sf_nxt, zf_nxt, of_nxt};

  assign set_cc = valid_in && (icode == 4'h6) && (ifun <= 4'h3) &&
                  !stall && !m_exc && !w_exc && (state == RUN);

  always_comb begin
    state_nxt = state;
    if (state == RUN && w_exc) begin
      state_nxt = FROZEN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      cf_reg  <= 3'b010;
      upd_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (set_cc) begin
        cf_reg  <= flags_nxt;
        upd_cnt <= upd_cnt + 16'd1;
      end
    end
  end

  assign frozen = (state == FROZEN);

`ifdef CC_BYPASS_EN
  assign cf = set_cc ? flags_nxt : cf_reg;
`else
  assign cf = cf_reg;
`endif

endmodule
